// File: rtl/fact_job_sequencer.sv
// Bus-master sequencer for one factorial job: it programs the device, waits for
// completion or a timeout, copies the 128-bit result to memory, then clears the device.
module fact_job_sequencer #(
   parameter logic [15:0] DEV_BASE = 16'h7000,
   parameter int          TIMEOUT  = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] operand,
   input  logic [15:0] dst_addr,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        m_req,
   input  logic        m_grant,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [63:0] m_dout,
   input  logic [63:0] m_din,
   input  logic        interrupt
);

   typedef enum logic [3:0] {
      IDLE, REQ, WR_OPND, WR_IEN, WR_START, WAIT_DONE, RD_H, ST_H,
      RD_L, ST_L, WR_CLR, WR_UNCLR, DONE
   } state_t;

   localparam logic [15:0] A_START    = DEV_BASE + 16'h0000;
   localparam logic [15:0] A_CLEAR    = DEV_BASE + 16'h0008;
   localparam logic [15:0] A_DONE     = DEV_BASE + 16'h0010;
   localparam logic [15:0] A_IEN      = DEV_BASE + 16'h0018;
   localparam logic [15:0] A_OPND     = DEV_BASE + 16'h0020;
   localparam logic [15:0] A_RES_H    = DEV_BASE + 16'h0028;
   localparam logic [15:0] A_RES_L    = DEV_BASE + 16'h0030;
   localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      nxt;
   logic [63:0] opnd_q;
   logic [15:0] dst_q;
   logic [63:0] rh;
   logic [63:0] rl;
   logic [63:0] rh_nxt;
   logic [63:0] rl_nxt;
   logic [15:0] wait_cnt;
   logic        timeout_hit;
   logic        wr_q;
   logic        nxt_wr;
   logic [15:0] nxt_addr;
   logic [63:0] nxt_dout;

   always_comb begin
      nxt         = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE:      if (start)   nxt = REQ;
         REQ:       if (m_grant) nxt = WR_OPND;
         WR_OPND:   if (m_grant) nxt = WR_IEN;
         WR_IEN:    if (m_grant) nxt = WR_START;
         WR_START:  if (m_grant) nxt = WAIT_DONE;
         // Completion wins over a timeout that lands in the same cycle.
         WAIT_DONE: begin
            if (m_grant && (interrupt || m_din[0])) begin
               nxt = RD_H;
            end else if (wait_cnt == WAIT_LAST) begin
               nxt         = WR_CLR;
               timeout_hit = 1'b1;
            end
         end
         RD_H:      if (m_grant) nxt = ST_H;
         ST_H:      if (m_grant) nxt = RD_L;
         RD_L:      if (m_grant) nxt = ST_L;
         ST_L:      if (m_grant) nxt = WR_CLR;
         WR_CLR:    if (m_grant) nxt = WR_UNCLR;
         WR_UNCLR:  if (m_grant) nxt = DONE;
         DONE:      nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   always_comb begin
      rh_nxt = (state == RD_H && m_grant) ? m_din : rh;
      rl_nxt = (state == RD_L && m_grant) ? m_din : rl;
   end

   // Bus outputs are decoded from the next state so they are registered and
   // line up with the cycle the FSM spends in that state.
   always_comb begin
      nxt_wr   = 1'b0;
      nxt_addr = 16'h0000;
      nxt_dout = 64'h0;
      case (nxt)
         WR_OPND:   begin nxt_wr = 1'b1; nxt_addr = A_OPND;  nxt_dout = opnd_q; end
         WR_IEN:    begin nxt_wr = 1'b1; nxt_addr = A_IEN;   nxt_dout = 64'd1;  end
         WR_START:  begin nxt_wr = 1'b1; nxt_addr = A_START; nxt_dout = 64'd1;  end
         WAIT_DONE: begin nxt_addr = A_DONE; end
         RD_H:      begin nxt_addr = A_RES_H; end
         ST_H:      begin nxt_wr = 1'b1; nxt_addr = dst_q;         nxt_dout = rh_nxt; end
         RD_L:      begin nxt_addr = A_RES_L; end
         ST_L:      begin nxt_wr = 1'b1; nxt_addr = dst_q + 16'd1; nxt_dout = rl_nxt; end
         WR_CLR:    begin nxt_wr = 1'b1; nxt_addr = A_CLEAR; nxt_dout = 64'd1;  end
         WR_UNCLR:  begin nxt_wr = 1'b1; nxt_addr = A_CLEAR; nxt_dout = 64'd0;  end
         default:   begin nxt_wr = 1'b0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         opnd_q   <= 64'h0;
         dst_q    <= 16'h0000;
         rh       <= 64'h0;
         rl       <= 64'h0;
         wait_cnt <= 16'h0000;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         m_req    <= 1'b0;
         wr_q     <= 1'b0;
         m_addr   <= 16'h0000;
         m_dout   <= 64'h0;
      end else begin
         state <= nxt;
         rh    <= rh_nxt;
         rl    <= rl_nxt;
         if (state == IDLE && start) begin
            opnd_q <= operand;
            dst_q  <= dst_addr;
            err    <= 1'b0;
         end else if (timeout_hit) begin
            err <= 1'b1;
         end
         wait_cnt <= (state == WAIT_DONE) ? wait_cnt + 16'd1 : 16'h0000;
         busy     <= (nxt != IDLE);
         done     <= (nxt == DONE);
         m_req    <= (nxt != IDLE) && (nxt != DONE);
         wr_q     <= nxt_wr;
         m_addr   <= nxt_addr;
         m_dout   <= nxt_dout;
      end
   end

   // A withdrawn grant must suppress the write strobe in the same cycle.
   assign m_wr = wr_q & m_grant;

endmodule

// File: tb/tb_fact_job_sequencer.sv
// Directed bench for fact_job_sequencer with a behavioural factorial device and
// a memory model that records every granted write outside the device window.
module tb_fact_job_sequencer;

   localparam logic [15:0] BASE = 16'h7000;
   localparam int          TMO  = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] operand;
   logic [15:0] dst_addr;
   logic        busy;
   logic        done;
   logic        err;
   logic        m_req;
   logic        m_grant;
   logic        m_wr;
   logic [15:0] m_addr;
   logic [63:0] m_dout;
   logic [63:0] m_din;
   logic        interrupt;

   logic         dev_hang;
   logic         dev_run;
   logic         dev_done;
   logic         dev_ien;
   logic [7:0]   dev_cnt;
   logic [63:0]  dev_opnd;
   logic [127:0] dev_res;

   logic [63:0] mem [logic [15:0]];
   logic [63:0] clr_q [$];
   int          done_cnt = 0;
   int          viol_cnt = 0;
   int          wr_cnt = 0;
   int          wait_cycles = 0;

   int checks = 0;
   int fails = 0;

   fact_job_sequencer #(.DEV_BASE(BASE), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .operand(operand), .dst_addr(dst_addr),
      .busy(busy), .done(done), .err(err), .m_req(m_req), .m_grant(m_grant),
      .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din), .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] fact(input logic [63:0] n);
      logic [127:0] r = 128'd1;
      for (int i = 2; i <= int'(n[7:0]); i++) r = r * 128'(i);
      return r;
   endfunction

   // Device raises opdone (and the interrupt if enabled) 50 cycles after opstart.
   always @(posedge clk) begin
      if (reset) begin
         dev_run  <= 1'b0;
         dev_done <= 1'b0;
         dev_ien  <= 1'b0;
         dev_cnt  <= 8'd0;
         dev_opnd <= 64'h0;
         dev_res  <= 128'h0;
      end else begin
         if (dev_run && !dev_hang) begin
            if (dev_cnt == 8'd49) begin
               dev_done <= 1'b1;
               dev_run  <= 1'b0;
            end
            dev_cnt <= dev_cnt + 8'd1;
         end
         if (m_wr && m_grant) begin
            case (m_addr)
               BASE + 16'h20: dev_opnd <= m_dout;
               BASE + 16'h18: dev_ien  <= m_dout[0];
               BASE + 16'h00: if (m_dout[0]) begin
                  dev_run  <= 1'b1;
                  dev_cnt  <= 8'd0;
                  dev_done <= 1'b0;
                  dev_res  <= fact(dev_opnd);
               end
               BASE + 16'h08: if (m_dout[0]) begin
                  dev_run  <= 1'b0;
                  dev_done <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign interrupt = dev_done & dev_ien;
   assign m_din = (m_addr == BASE + 16'h10) ? {63'b0, dev_done} :
                  (m_addr == BASE + 16'h28) ? dev_res[127:64] :
                  (m_addr == BASE + 16'h30) ? dev_res[63:0] : 64'h0;

   always @(negedge clk) begin
      if (m_wr && !m_grant) viol_cnt++;
      if (m_wr && m_grant) begin
         wr_cnt++;
         if (m_addr == BASE + 16'h08) clr_q.push_back(m_dout);
         else if (m_addr < BASE || m_addr > BASE + 16'h30) mem[m_addr] = m_dout;
      end
      if (done) done_cnt++;
      if (busy && m_addr == BASE + 16'h10) wait_cycles++;
   end

   function automatic logic [63:0] memAt(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return 64'hx;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [63:0] op, input logic [15:0] dst);
      @(posedge clk);
      #1;
      start    = 1'b1;
      operand  = op;
      dst_addr = dst;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int limit);
      int n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, {63'b0, busy}, 64'h0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},  {63'b0, busy},  64'h0);
      checkOutput({tag, "_done"},  {63'b0, done},  64'h0);
      checkOutput({tag, "_err"},   {63'b0, err},   64'h0);
      checkOutput({tag, "_mreq"},  {63'b0, m_req}, 64'h0);
      checkOutput({tag, "_mwr"},   {63'b0, m_wr},  64'h0);
      checkOutput({tag, "_maddr"}, {48'b0, m_addr}, 64'h0);
      checkOutput({tag, "_mdout"}, m_dout,         64'h0);
   endtask

   initial begin
      int b_done;
      int b_clr;
      int b_viol;
      int b_wait;
      int b_wr;
      int n;

      reset    = 1'b1;
      start    = 1'b0;
      operand  = 64'h0;
      dst_addr = 16'h0000;
      m_grant  = 1'b1;
      dev_hang = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      @(posedge clk);
      #1 reset = 1'b0;

      $display("[TB] job 12! to 0x000A");
      b_done = done_cnt;
      b_clr  = clr_q.size();
      applyStimulus(64'd12, 16'h000A);
      waitIdle("s1_finish", 500);
      checkOutput("s1_res_h", memAt(16'h000A), 64'd0);
      checkOutput("s1_res_l", memAt(16'h000B), 64'd479001600);
      checkOutput("s1_err", {63'b0, err}, 64'h0);
      checkOutput("s1_done_pulses", 64'(done_cnt - b_done), 64'd1);
      checkOutput("s1_clr_count", 64'(clr_q.size() - b_clr), 64'd2);
      checkOutput("s1_clr_first", clr_q[b_clr], 64'd1);
      checkOutput("s1_clr_second", clr_q[b_clr + 1], 64'd0);

      $display("[TB] job 0! to 0x00AA");
      applyStimulus(64'd0, 16'h00AA);
      waitIdle("s2_finish", 500);
      checkOutput("s2_res_h", memAt(16'h00AA), 64'd0);
      checkOutput("s2_res_l", memAt(16'h00AB), 64'd1);

      $display("[TB] job 12! with grant stalls");
      b_done  = done_cnt;
      b_viol  = viol_cnt;
      m_grant = 1'b0;
      applyStimulus(64'd12, 16'h000C);
      repeat (19) @(posedge clk);
      #1;
      checkOutput("s3_req_busy", {63'b0, busy}, 64'd1);
      checkOutput("s3_req_mreq", {63'b0, m_req}, 64'd1);
      checkOutput("s3_req_mwr", {63'b0, m_wr}, 64'd0);
      m_grant = 1'b1;
      n = 0;
      while (m_addr != BASE + 16'h28 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("s3_reach_rdh", {48'b0, m_addr}, {48'b0, BASE + 16'h28});
      @(posedge clk);
      #1 m_grant = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("s3_sth_mwr", {63'b0, m_wr}, 64'd0);
      end
      checkOutput("s3_sth_hold", {48'b0, m_addr}, 64'h000C);
      @(posedge clk);
      #1 m_grant = 1'b1;
      waitIdle("s3_finish", 500);
      checkOutput("s3_res_h", memAt(16'h000C), 64'd0);
      checkOutput("s3_res_l", memAt(16'h000D), 64'd479001600);
      checkOutput("s3_no_ungranted_wr", 64'(viol_cnt - b_viol), 64'd0);
      checkOutput("s3_done_pulses", 64'(done_cnt - b_done), 64'd1);

      $display("[TB] hung device, timeout path");
      dev_hang = 1'b1;
      b_done   = done_cnt;
      b_clr    = clr_q.size();
      b_wait   = wait_cycles;
      applyStimulus(64'd7, 16'h0100);
      waitIdle("s4_finish", 500);
      checkOutput("s4_err", {63'b0, err}, 64'd1);
      checkOutput("s4_wait_cycles", 64'(wait_cycles - b_wait), 64'd64);
      checkOutput("s4_no_store_h", 64'(mem.exists(16'h0100)), 64'd0);
      checkOutput("s4_no_store_l", 64'(mem.exists(16'h0101)), 64'd0);
      checkOutput("s4_clr_count", 64'(clr_q.size() - b_clr), 64'd2);
      checkOutput("s4_clr_first", clr_q[b_clr], 64'd1);
      checkOutput("s4_clr_second", clr_q[b_clr + 1], 64'd0);
      checkOutput("s4_done_pulses", 64'(done_cnt - b_done), 64'd1);
      dev_hang = 1'b0;

      $display("[TB] second start while busy");
      b_done = done_cnt;
      applyStimulus(64'd3, 16'h0020);
      checkOutput("s5_err_cleared", {63'b0, err}, 64'd0);
      start    = 1'b1;
      operand  = 64'd10;
      dst_addr = 16'h0040;
      @(posedge clk);
      #1 start = 1'b0;
      checkOutput("s5_opnd_addr", {48'b0, m_addr}, {48'b0, BASE + 16'h20});
      checkOutput("s5_opnd_data", m_dout, 64'd3);
      waitIdle("s5_finish", 500);
      checkOutput("s5_res_l", memAt(16'h0021), 64'd6);
      checkOutput("s5_no_second_job", 64'(mem.exists(16'h0041)), 64'd0);
      checkOutput("s5_done_pulses", 64'(done_cnt - b_done), 64'd1);

      $display("[TB] reset during wait");
      applyStimulus(64'd4, 16'h0050);
      n = 0;
      while (m_addr != BASE + 16'h10 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("s6_reach_wait", {48'b0, m_addr}, {48'b0, BASE + 16'h10});
      b_wr  = wr_cnt;
      b_clr = clr_q.size();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkAllZero("s6_after_reset");
      repeat (10) @(negedge clk);
      checkOutput("s6_no_writes", 64'(wr_cnt - b_wr), 64'd0);
      checkOutput("s6_no_clear", 64'(clr_q.size() - b_clr), 64'd0);
      applyStimulus(64'd5, 16'h0060);
      waitIdle("s6_finish", 500);
      checkOutput("s6_res_l", memAt(16'h0061), 64'd120);

      $display("[TB] destination wrap at 0xFFFF");
      applyStimulus(64'd1, 16'hFFFF);
      waitIdle("s7_finish", 500);
      checkOutput("s7_res_h", memAt(16'hFFFF), 64'd0);
      checkOutput("s7_res_l_wrapped", memAt(16'h0000), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
